// File: rtl/vg8020_ram_pkg.sv
// rtl/vg8020_ram_pkg.sv - shared FSM encoding and default timing for the VG8020 slot-3 DRAM path
package vg8020_ram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_COL,
        ST_RFSH,
        ST_SELF,
        ST_PRE
    } ras_state_t;

    localparam int DEF_TRCD_CYC  = 1;
    localparam int DEF_MREQD_CYC = 2;
    localparam int DEF_TRP_CYC   = 2;
    localparam int DEF_RFSH_MAX  = 320;
    localparam int DEF_ROW_W     = 7;

    // Width of the phase counters used for RCD, precharge and self-refresh timing.
    localparam int PHASE_W = 8;

endpackage

// File: rtl/dram_ras_sequencer_if.sv
// rtl/dram_ras_sequencer_if.sv - Z80 strobe inputs and DRAM control outputs of the RAS sequencer
interface dram_ras_sequencer_if
    import vg8020_ram_pkg::*;
#(
    parameter int ROW_W = DEF_ROW_W
) ();
    logic             nmreq;
    logic             nrfsh;
    logic             nsltsl3;
    logic             nras;
    logic             mux;
    logic             nmreqd;
    logic             nrfshd;
    logic             nwait;
    logic             self_rfsh;
    logic [ROW_W-1:0] rfsh_row;

    modport master (
        output nmreq, nrfsh, nsltsl3,
        input  nras, mux, nmreqd, nrfshd, nwait, self_rfsh, rfsh_row
    );

    modport slave (
        input  nmreq, nrfsh, nsltsl3,
        output nras, mux, nmreqd, nrfshd, nwait, self_rfsh, rfsh_row
    );
endinterface

// File: rtl/refresh_starve_timer.sv
// rtl/refresh_starve_timer.sv - saturating refresh-starvation counter and internal refresh row counter
module refresh_starve_timer
    import vg8020_ram_pkg::*;
#(
    parameter int RFSH_MAX = DEF_RFSH_MAX,
    parameter int ROW_W    = DEF_ROW_W
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             clear,
    input  logic             row_inc,
    output logic             fire,
    output logic [ROW_W-1:0] rfsh_row
);
    localparam int            CW      = $clog2(RFSH_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RFSH_MAX);

    logic [CW-1:0] starve;

    // Count cycles since the last refresh, holding at the limit; advance the row after each self refresh.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            starve   <= '0;
            rfsh_row <= '0;
        end else begin
            if (clear) begin
                starve <= '0;
            end else if (starve != CNT_MAX) begin
                starve <= starve + 1'b1;
            end
            if (row_inc) begin
                rfsh_row <= rfsh_row + 1'b1;
            end
        end
    end

    assign fire = (starve == CNT_MAX);

endmodule

// File: rtl/dram_ras_sequencer.sv
// rtl/dram_ras_sequencer.sv - RAS/mux sequencer with forced refresh for the VG8020 slot-3 DRAM bank
module dram_ras_sequencer
    import vg8020_ram_pkg::*;
#(
    parameter int TRCD_CYC  = DEF_TRCD_CYC,
    parameter int MREQD_CYC = DEF_MREQD_CYC,
    parameter int TRP_CYC   = DEF_TRP_CYC,
    parameter int RFSH_MAX  = DEF_RFSH_MAX,
    parameter int ROW_W     = DEF_ROW_W
) (
    input logic                 clk,
    input logic                 nreset,
    dram_ras_sequencer_if.slave bus
);
    localparam logic [PHASE_W-1:0] TRCD_LAST = PHASE_W'(TRCD_CYC - 1);
    localparam logic [PHASE_W-1:0] TRP_LAST  = PHASE_W'(TRP_CYC - 1);
    localparam logic [PHASE_W-1:0] SELF_LAST = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] MREQD_N   = PHASE_W'(MREQD_CYC);

    ras_state_t         state;
    logic [PHASE_W-1:0] tcnt;
    logic [PHASE_W-1:0] mcnt;
    logic               nras_q;
    logic               mux_q;
    logic               nmreqd_q;
    logic               nrfshd_q;
    logic               nwait_q;
    logic               self_q;
    logic               access;
    logic               z80_rfsh;
    logic               self_done;
    logic               rfsh_done;
    logic               starve_fire;
    logic [ROW_W-1:0]   row;

    assign access    = !bus.nmreq && bus.nrfsh && !bus.nsltsl3;
    assign z80_rfsh  = !bus.nmreq && !bus.nrfsh;
    assign self_done = (state == ST_SELF) && (tcnt == SELF_LAST);
    assign rfsh_done = (state == ST_RFSH) && bus.nmreq;

    refresh_starve_timer #(
        .RFSH_MAX (RFSH_MAX),
        .ROW_W    (ROW_W)
    ) u_timer (
        .clk      (clk),
        .nreset   (nreset),
        .clear    (self_done || rfsh_done),
        .row_inc  (self_done),
        .fire     (starve_fire),
        .rfsh_row (row)
    );

    // Cycle sequencer: decodes Z80 strobes, times RAS/mux phases and drives all strobes from registers.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state    <= ST_IDLE;
            tcnt     <= '0;
            mcnt     <= '0;
            nras_q   <= 1'b1;
            mux_q    <= 1'b0;
            nmreqd_q <= 1'b1;
            nrfshd_q <= 1'b1;
            nwait_q  <= 1'b1;
            self_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    nwait_q <= 1'b1;
                    tcnt    <= '0;
                    if (access) begin
                        state  <= ST_ROW;
                        nras_q <= 1'b0;
                        mcnt   <= PHASE_W'(1);
                    end else if (z80_rfsh) begin
                        state    <= ST_RFSH;
                        nras_q   <= 1'b0;
                        nrfshd_q <= 1'b0;
                    end else if (starve_fire) begin
                        state  <= ST_SELF;
                        nras_q <= 1'b0;
                        self_q <= 1'b1;
                    end
                end
                ST_ROW: begin
                    if (mcnt != '1) begin
                        mcnt <= mcnt + 1'b1;
                    end
                    if (tcnt == TRCD_LAST) begin
                        state <= ST_COL;
                        mux_q <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                    // The delayed strobe must be down by the first column cycle even if MREQD is longer.
                    if (bus.nmreq) begin
                        nmreqd_q <= 1'b1;
                    end else if ((mcnt >= MREQD_N) || (tcnt == TRCD_LAST)) begin
                        nmreqd_q <= 1'b0;
                    end
                end
                ST_COL: begin
                    if (bus.nmreq) begin
                        state    <= ST_PRE;
                        tcnt     <= '0;
                        nras_q   <= 1'b1;
                        mux_q    <= 1'b0;
                        nmreqd_q <= 1'b1;
                    end else begin
                        nmreqd_q <= 1'b0;
                    end
                end
                ST_RFSH: begin
                    if (bus.nmreq) begin
                        state    <= ST_PRE;
                        tcnt     <= '0;
                        nras_q   <= 1'b1;
                        nrfshd_q <= 1'b1;
                    end
                end
                ST_SELF: begin
                    nwait_q <= !access;
                    if (tcnt == SELF_LAST) begin
                        state  <= ST_PRE;
                        tcnt   <= '0;
                        nras_q <= 1'b1;
                        self_q <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_PRE: begin
                    nwait_q <= !access;
                    if (tcnt == TRP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    nras_q <= 1'b1;
                    mux_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.nras      = nras_q;
    assign bus.mux       = mux_q;
    assign bus.nmreqd    = nmreqd_q;
    assign bus.nrfshd    = nrfshd_q;
    assign bus.nwait     = nwait_q;
    assign bus.self_rfsh = self_q;
    assign bus.rfsh_row  = row;

endmodule

// File: tb/tb_dram_ras_sequencer.sv
// tb/tb_dram_ras_sequencer.sv - randomized self-checking bench for dram_ras_sequencer
module tb_dram_ras_sequencer;

    localparam int TRCD     = 1;
    localparam int MREQD    = 2;
    localparam int TRP      = 2;
    localparam int RFSH_MAX = 320;
    localparam int ROW_W    = 7;
    localparam int ROWS     = 1 << ROW_W;

    // {nras, mux, nmreqd, nrfshd, nwait, self_rfsh}
    localparam logic [5:0] IDLE_OUTS = 6'b101110;
    localparam logic [5:0] SELF_OUTS = 6'b001111;
    localparam logic [5:0] ROW_OUTS  = 6'b001110;
    localparam logic [5:0] COL_OUTS  = 6'b010110;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dram_ras_sequencer_if #(.ROW_W(ROW_W)) bus ();

    dram_ras_sequencer #(
        .TRCD_CYC  (TRCD),
        .MREQD_CYC (MREQD),
        .TRP_CYC   (TRP),
        .RFSH_MAX  (RFSH_MAX),
        .ROW_W     (ROW_W)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {bus.nras, bus.mux, bus.nmreqd, bus.nrfshd, bus.nwait, bus.self_rfsh};
    endfunction

    // Expected outputs k edges after an access is first presented from IDLE, held L cycles.
    function automatic logic [5:0] exp_access(int k, int L);
        int  fall;
        logic on;
        fall = 1 + ((MREQD < TRCD) ? MREQD : TRCD);
        on   = (k >= 1) && (k <= L);
        return {!on, (k >= 1 + TRCD) && (k <= L), !((k >= fall) && (k <= L)), 1'b1, 1'b1, 1'b0};
    endfunction

    // Expected outputs k edges after a Z80 refresh is first presented from IDLE, held R cycles.
    function automatic logic [5:0] exp_rfsh(int k, int R);
        logic on;
        on = (k >= 1) && (k <= R);
        return {!on, 1'b0, 1'b1, !on, 1'b1, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.nmreq   = 1'b1;
        bus.nrfsh   = 1'b1;
        bus.nsltsl3 = 1'b1;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        idle_inputs();
        repeat (3) tick();
        nreset = 1'b1;
    endtask

    task automatic wait_self(output int n);
        n = 0;
        while (bus.self_rfsh !== 1'b1 && n < RFSH_MAX + 20) begin
            tick();
            n++;
        end
    endtask

    task automatic run_rfsh(input int R);
        bus.nmreq = 1'b0;
        bus.nrfsh = 1'b0;
        bus.nsltsl3 = 1'($urandom_range(0, 1));
        for (int k = 1; k <= R + 1 + TRP; k++) begin
            tick();
            checks++;
            if (outs() !== exp_rfsh(k, R)) begin
                errors++;
                $display("FAIL rfsh R=%0d k=%0d: got %b expected %b", R, k, outs(), exp_rfsh(k, R));
            end
            bus.nsltsl3 = 1'($urandom_range(0, 1));
            if (k == R) idle_inputs();
        end
    endtask

    task automatic run_access(input int L, input int rise);
        bus.nmreq = 1'b0;
        bus.nrfsh = 1'b1;
        bus.nsltsl3 = 1'b0;
        for (int k = 1; k <= L + 1 + TRP; k++) begin
            tick();
            checks++;
            if (outs() !== exp_access(k, L)) begin
                errors++;
                $display("FAIL access L=%0d k=%0d: got %b expected %b", L, k, outs(), exp_access(k, L));
            end
            if (k == rise) bus.nsltsl3 = 1'b1;
            if (k == L) idle_inputs();
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        bus.nmreq = 1'b0;
        bus.nrfsh = 1'b1;
        bus.nsltsl3 = 1'b0;
        repeat (3) tick();
        checks++;
        if (outs() !== IDLE_OUTS || bus.rfsh_row !== '0) begin
            errors++;
            $display("FAIL reset_values: got %b row %0d expected %b row 0", outs(), bus.rfsh_row, IDLE_OUTS);
        end
        nreset = 1'b1;
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (outs() !== IDLE_OUTS) begin
                errors++;
                $display("FAIL reset_release k=%0d: got %b expected %b", k, outs(), IDLE_OUTS);
            end
        end
    endtask

    task automatic test_random_traffic();
        do_reset();
        for (int it = 0; it < 12; it++) begin
            int L;
            int gap;
            run_rfsh($urandom_range(1, 6));
            L = $urandom_range(2, 10);
            run_access(L, $urandom_range(1, L));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                tick();
                checks++;
                if (outs() !== IDLE_OUTS) begin
                    errors++;
                    $display("FAIL idle_gap it=%0d: got %b expected %b", it, outs(), IDLE_OUTS);
                end
            end
        end
    endtask

    task automatic test_foreign_and_reset();
        do_reset();
        bus.nmreq = 1'b0;
        bus.nrfsh = 1'b1;
        bus.nsltsl3 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (outs() !== IDLE_OUTS) begin
                errors++;
                $display("FAIL foreign_slot k=%0d: got %b expected %b", k, outs(), IDLE_OUTS);
            end
        end
        idle_inputs();
        tick();
        bus.nmreq = 1'b0;
        bus.nsltsl3 = 1'b0;
        tick();
        tick();
        checks++;
        if (outs() !== COL_OUTS) begin
            errors++;
            $display("FAIL pre_reset_col: got %b expected %b", outs(), COL_OUTS);
        end
        #2;
        nreset = 1'b0;
        tick();
        checks++;
        if (outs() !== IDLE_OUTS) begin
            errors++;
            $display("FAIL reset_in_col: got %b expected %b", outs(), IDLE_OUTS);
        end
        nreset = 1'b1;
        idle_inputs();
    endtask

    task automatic test_collision();
        int n;
        do_reset();
        wait_self(n);
        checks++;
        if (n != RFSH_MAX + 1) begin
            errors++;
            $display("FAIL collision_self_start: got %0d cycles expected %0d", n, RFSH_MAX + 1);
        end
        bus.nmreq = 1'b0;
        bus.nrfsh = 1'b1;
        bus.nsltsl3 = 1'b0;
        for (int k = 1; k <= 2 + TRP; k++) begin
            tick();
            checks++;
            if (bus.nwait !== 1'b0) begin
                errors++;
                $display("FAIL collision_nwait k=%0d: got %b expected 0", k, bus.nwait);
            end
        end
        tick();
        checks++;
        if (outs() !== ROW_OUTS) begin
            errors++;
            $display("FAIL collision_row: got %b expected %b", outs(), ROW_OUTS);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (outs() !== COL_OUTS) begin
                errors++;
                $display("FAIL collision_col k=%0d: got %b expected %b", k, outs(), COL_OUTS);
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (outs() !== IDLE_OUTS) begin
            errors++;
            $display("FAIL collision_end: got %b expected %b", outs(), IDLE_OUTS);
        end
    endtask

    task automatic test_refresh_clears();
        int n;
        do_reset();
        repeat ($urandom_range(50, 250)) tick();
        run_rfsh($urandom_range(1, 6));
        wait_self(n);
        checks++;
        if (n != RFSH_MAX + 1 - TRP) begin
            errors++;
            $display("FAIL rfsh_clears_counter: got %0d cycles expected %0d", n, RFSH_MAX + 1 - TRP);
        end
    endtask

    task automatic test_starvation();
        int n;
        int row_model;
        do_reset();
        row_model = 0;
        for (int i = 0; i < ROWS; i++) begin
            wait_self(n);
            checks++;
            if (n != RFSH_MAX + 1) begin
                errors++;
                $display("FAIL starve_gap i=%0d: got %0d cycles expected %0d", i, n, RFSH_MAX + 1);
            end
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (outs() !== SELF_OUTS) begin
                    errors++;
                    $display("FAIL self_cycle i=%0d c=%0d: got %b expected %b", i, c, outs(), SELF_OUTS);
                end
                tick();
            end
            row_model = (row_model + 1) % ROWS;
            checks++;
            if (outs() !== IDLE_OUTS || int'(bus.rfsh_row) != row_model) begin
                errors++;
                $display("FAIL self_exit i=%0d: got %b row %0d expected %b row %0d",
                         i, outs(), bus.rfsh_row, IDLE_OUTS, row_model);
            end
        end
        checks++;
        if (bus.rfsh_row !== '0) begin
            errors++;
            $display("FAIL row_wrap: got %0d expected 0", bus.rfsh_row);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_random_traffic();
        test_foreign_and_reset();
        test_collision();
        test_refresh_clears();
        test_starvation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_ras_sequencer.md
# dram_ras_sequencer

Synchronous RAS/address-mux sequencer for the VG8020 slot-3 DRAM bank, sitting directly upstream of `cas_control`. It samples the Z80 memory strobes and produces:
- `nras`;
- the row/column address-mux select;
- the delayed strobes `nmreqd` and `nrfshd` that `cas_control` consumes.

It also guarantees refresh when the Z80 stops refreshing, for example during long bus holds. In that case it runs internal refresh cycles and stalls any colliding access through `nwait`.

## Interface
Parameters:
- `TRCD_CYC`, default 1: clk cycles `nras` is low with `mux` on row before switching to column.
- `MREQD_CYC`, default 2: clk cycles from access start to `nmreqd` falling.
- `TRP_CYC`, default 2: minimum clk cycles `nras` is high between cycles (precharge).
- `RFSH_MAX`, default 320: clk cycles without a refresh before an internal refresh is forced.
- `ROW_W`, default 7: width of the internal refresh row counter.

Ports:
- `clk` input 1: master clock; every input is synchronous to it.
- `nreset` input 1: synchronous, active-low reset.
- `nmreq` input 1: Z80 /MREQ.
- `nrfsh` input 1: Z80 /RFSH.
- `nsltsl3` input 1: slot-3 select.
- `nras` output 1: DRAM /RAS.
- `mux` output 1: address mux select, 0 = row, 1 = column.
- `nmreqd` output 1: delayed /MREQ to `cas_control`.
- `nrfshd` output 1: registered refresh flag to `cas_control`.
- `nwait` output 1: Z80 /WAIT; low while an access is held off.
- `self_rfsh` output 1: high while an internal refresh owns the DRAM address bus.
- `rfsh_row` output `ROW_W`: internal refresh row address.

## Operation
- Request decode, sampled each `clk`:
  - access = `nmreq`=0 & `nrfsh`=1 & `nsltsl3`=0;
  - Z80 refresh = `nmreq`=0 & `nrfsh`=0, independent of slot.
- FSM states are IDLE, ROW, COL, RFSH, SELF, PRE.
- IDLE:
  - access goes to ROW;
  - Z80 refresh goes to RFSH;
  - otherwise, starvation counter = `RFSH_MAX` goes to SELF.
  - Precedence: access > Z80 refresh > self refresh.
- ROW:
  - `nras`=0, `mux`=0;
  - after `TRCD_CYC` cycles goes to COL.
- COL:
  - `nras`=0, `mux`=1;
  - stays while `nmreq`=0;
  - `nmreq` sampled 1 goes to PRE.
- RFSH:
  - `nras`=0, `mux`=0, `nrfshd`=0;
  - `nmreq` sampled 1 goes to PRE.
- SELF:
  - `nras`=0, `mux`=0, `self_rfsh`=1;
  - lasts exactly 2 cycles, then goes to PRE;
  - `rfsh_row` increments by 1 on exit, wrapping 2^`ROW_W`−1 to 0.
- PRE:
  - `nras`=1, `mux`=0;
  - after `TRP_CYC` cycles goes to IDLE.
  - A request still pending at exit is decoded in IDLE on the next cycle.
- `nmreqd`:
  - falls `MREQD_CYC` cycles after entry to ROW, clamped so it falls no later than the first COL cycle;
  - rises the cycle after `nmreq` is sampled 1;
  - is always 1 outside ROW/COL.
- `nwait`:
  - low while an access is decoded but the FSM is in SELF or PRE;
  - high from the cycle the FSM enters ROW.
  - Never asserted for Z80 refresh.
- Starvation counter:
  - cleared on exit of RFSH or SELF;
  - otherwise increments;
  - saturates at `RFSH_MAX`.
- A Z80 refresh arriving during SELF or PRE waits in PRE/IDLE and then runs normally.

## Timing
- Reset values:
  - `nras`=1, `mux`=0, `nmreqd`=1, `nrfshd`=1, `nwait`=1, `self_rfsh`=0;
  - `rfsh_row`=0, starvation counter 0, FSM in IDLE.
- All outputs are registered; there are no combinational input-to-output paths.
- Access latency: `nmreq`/`nsltsl3` sampled low at edge N gives `nras`=0 after edge N+1 and `mux`=1 after edge N+1+`TRCD_CYC`.
- `nreset`=0 mid-cycle forces the reset values on the next edge, even with `nras` low. DRAM precharge violation on reset is accepted.
- An access with `nsltsl3`=1 is ignored; the FSM stays IDLE and the counter keeps running.
- `nsltsl3` rising during COL does not end the cycle; only `nmreq` ends it.

## Structure
- Shared package `vg8020_ram_pkg`:
  - FSM state encoding;
  - default timing constants (`TRCD_CYC`, `MREQD_CYC`, `TRP_CYC`, `RFSH_MAX`, `ROW_W`).
- One sub-module `refresh_starve_timer`: the saturating counter plus the `rfsh_row` counter, with clear/inc/fire interface.
- The FSM and strobe logic live in the top module.

## Test plan
- Reset: hold `nreset`=0 for 3 cycles → all outputs at their reset values. Release → `nras` stays 1 with idle inputs.
- Slot-3 read: `nmreq`=0 and `nsltsl3`=0 at edge 0, held for 8 cycles.
  - `nras` 0 from edge 1, `mux` 1 from edge 2, `nmreqd` 0 from edge 2.
  - After `nmreq`=1: `nras`/`nmreqd` 1 on the next edge, then `nras` high ≥2 cycles.
- Z80 refresh: `nmreq`=0 and `nrfsh`=0 for 4 cycles.
  - `nras`=0 and `nrfshd`=0 with `mux`=0 throughout; `nmreqd` stays 1.
  - The starvation counter clears.
- Starvation: idle for 320 cycles.
  - `self_rfsh`=1 and `nras`=0 for 2 cycles, then `rfsh_row` goes 0→1.
  - Repeating 128 times returns `rfsh_row` to 0.
- Collision: access requested on the first SELF cycle.
  - `nwait`=0 for 2+`TRP_CYC` cycles, then ROW entry with `nwait`=1.
  - The access completes normally.
- Foreign slot and mid-access reset:
  - `nsltsl3`=1 access → no `nras` activity.
  - `nreset`=0 during COL → `nras`=1, `mux`=0, `nmreqd`=1 on the next edge.
